fbuf_bank_ctrl: RTL

//  Ping-pong frame buffer controller between camera capture (writer) and display_interface (reader).

---
 rtl/fbuf_pkg.sv | 21 ++
 rtl/fbuf_wr_ctrl.sv | 98 +++++++++
 rtl/fbuf_bank_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fbuf_pkg.sv
// Shared definitions for the ping-pong frame buffer controller.
// Holds the writer state encoding, default geometry and bank reset values.
// Contents: wr_state_e, FBUF_DEPTH_DEF/ADDR_W_DEF/DATA_W_DEF, RD_BANK_RST/WR_BANK_RST.
package fbuf_pkg;

    // One 640x480 RGB565 frame per bank by default.
    localparam int FBUF_DEPTH_DEF = 307200;
    localparam int ADDR_W_DEF     = 19;
    localparam int DATA_W_DEF     = 16;

    // Display starts on bank 0 and capture fills bank 1, so they never coincide.
    localparam logic RD_BANK_RST = 1'b0;
    localparam logic WR_BANK_RST = 1'b1;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,   // no frame in progress, pixels are discarded
        WR_WRITE = 2'd1,   // filling the write bank
        WR_DONE  = 2'd2    // write bank full, waiting for the next capture SOF
    } wr_state_e;

endpackage

// File: rtl/fbuf_wr_ctrl.sv
// Capture-side writer FSM: tracks the word counter, pending-frame flag, overflow and dropped frames.
// Latency: store_o/word_o are combinational from the accepted pixel; overflow_o is a registered 1-cycle pulse.
// Backpressure: none of its own; acc_i is already qualified by the read-priority arbiter in the top.
// Ports: clk_i/rst_i (sync, active-high), sof_i capture SOF, acc_i pixel accepted, swap_i bank swap this cycle,
//        store_o/word_o write this pixel at word_o, pending_o complete frame waiting, overflow_o, drop_cnt_o.
module fbuf_wr_ctrl
    import fbuf_pkg::*;
#(
    parameter int FBUF_DEPTH = FBUF_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sof_i,
    input  logic              acc_i,
    input  logic              swap_i,
    output logic              store_o,
    output logic [ADDR_W-1:0] word_o,
    output logic              pending_o,
    output logic              overflow_o,
    output logic [7:0]        drop_cnt_o
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FBUF_DEPTH - 1);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic              pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_q, drop_d;

    // An SOF restarts the frame in the same cycle, so a pixel arriving with it is word 0.
    logic              in_frame;
    logic [ADDR_W-1:0] cur_word;

    assign in_frame = (state_q == WR_WRITE) || sof_i;
    assign cur_word = sof_i ? '0 : wcnt_q;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        pending_d  = pending_q;
        overflow_d = 1'b0;
        drop_d     = drop_q;
        store_o    = 1'b0;
        word_o     = cur_word;

        if (sof_i) begin
            state_d = WR_WRITE;
            wcnt_d  = '0;
        end

        if (acc_i) begin
            if (in_frame) begin
                store_o = 1'b1;
                wcnt_d  = cur_word + ADDR_W'(1);
                if (cur_word == LAST_WORD) begin
                    state_d   = WR_DONE;
                    wcnt_d    = '0;
                    pending_d = 1'b1;
                    // The previous complete frame was never displayed and is now overwritten.
                    if (pending_q && (drop_q != 8'hFF)) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end else if (state_q == WR_DONE) begin
                overflow_d = 1'b1;
            end
        end

        // A swap consumes the pending frame; it wins over a completion in the same
        // cycle because that completion landed in the bank being handed to display.
        if (swap_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= WR_IDLE;
            wcnt_q     <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: rtl/fbuf_bank_ctrl.sv
// Ping-pong frame buffer controller sharing one single-port RAM between capture (write) and display (read).
// Latency: RAM address/we registered 1 cycle after request; o_rd_valid 2 cycles after i_rd_en.
// Backpressure: reads have strict priority; o_wr_ready = !i_rd_en and a stalled pixel is held by the writer.
// Ports: i_clk/i_rst, capture i_wr_sof/i_wr_valid/i_wr_data/o_wr_ready, display i_rd_sof/i_rd_en/i_rd_addr/
//        o_rd_valid/o_rd_data, RAM o_mem_addr/o_mem_we/o_mem_wdata/i_mem_rdata, status o_rd_bank/o_frame_valid/
//        o_overflow/o_drop_cnt.
module fbuf_bank_ctrl
    import fbuf_pkg::*;
#(
    parameter int FBUF_DEPTH = FBUF_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_sof,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_rd_sof,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [ADDR_W:0]   o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_rd_bank,
    output logic              o_frame_valid,
    output logic              o_overflow,
    output logic [7:0]        o_drop_cnt
);

    logic              wr_acc;
    logic              wr_store;
    logic [ADDR_W-1:0] wr_word;
    logic              pending;
    logic              swap;

    logic              rd_bank_q, rd_bank_d;
    logic              wr_bank_q, wr_bank_d;
    logic              frame_valid_q, frame_valid_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    assign o_wr_ready = !i_rd_en;
    assign wr_acc     = i_wr_valid && !i_rd_en;
    // pending is registered, so a frame completing this cycle cannot swap until the next display SOF.
    assign swap       = i_rd_sof && pending;

    fbuf_wr_ctrl #(
        .FBUF_DEPTH (FBUF_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_wr_ctrl (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .sof_i      (i_wr_sof),
        .acc_i      (wr_acc),
        .swap_i     (swap),
        .store_o    (wr_store),
        .word_o     (wr_word),
        .pending_o  (pending),
        .overflow_o (o_overflow),
        .drop_cnt_o (o_drop_cnt)
    );

    always_comb begin
        rd_bank_d     = rd_bank_q;
        wr_bank_d     = wr_bank_q;
        frame_valid_d = frame_valid_q;
        rd_en_d       = i_rd_en;
        rd_valid_d    = rd_en_q;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = 1'b0;
        mem_wdata_d   = mem_wdata_q;

        // wr_store implies !i_rd_en, so the two RAM requests never collide.
        if (i_rd_en) begin
            mem_addr_d = {rd_bank_q, i_rd_addr};
        end else if (wr_store) begin
            mem_addr_d  = {wr_bank_q, wr_word};
            mem_we_d    = 1'b1;
            mem_wdata_d = i_wr_data;
        end

        if (swap) begin
            rd_bank_d     = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
            frame_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_bank_q     <= RD_BANK_RST;
            wr_bank_q     <= WR_BANK_RST;
            frame_valid_q <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_valid_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
        end else begin
            rd_bank_q     <= rd_bank_d;
            wr_bank_q     <= wr_bank_d;
            frame_valid_q <= frame_valid_d;
            rd_en_q       <= rd_en_d;
            rd_valid_q    <= rd_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = i_mem_rdata;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_we      = mem_we_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_rd_bank     = rd_bank_q;
    assign o_frame_valid = frame_valid_q;

endmodule
